// File: rtl/apb_pkg.sv
// Shared widths, register indices and completer state type for the APB register completer.
package apb_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_SLAVE  = 4;
  localparam int unsigned IDX_WIDTH  = 3;
  localparam int unsigned WAIT_WIDTH = 4;
  localparam int unsigned NUM_SCRATCH = 4;

  typedef enum logic [IDX_WIDTH-1:0] {
    REG_CTRL     = 3'd0,
    REG_STATUS   = 3'd1,
    REG_IRQ      = 3'd2,
    REG_XFER_CNT = 3'd3,
    REG_SCRATCH0 = 3'd4,
    REG_SCRATCH1 = 3'd5,
    REG_SCRATCH2 = 3'd6,
    REG_SCRATCH3 = 3'd7
  } reg_idx_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Word-aligned and inside the 32-byte register window
  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[ADDR_WIDTH-1:5] == '0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_completer_fsm.sv
// IDLE/ACCESS handshake FSM with a wait-state counter; produces PREADY and a completion strobe.
module apb_completer_fsm
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic i_sel,
  input  logic i_penable,
  output logic o_pready,
  output logic o_access_c
);

  apb_state_e            r_state;
  apb_state_e            w_state_nxt;
  logic [WAIT_WIDTH-1:0] r_cnt;
  logic [WAIT_WIDTH-1:0] w_cnt_nxt;
  logic                  r_pready;
  logic                  w_pready_nxt;

  // State, wait counter and ready flag registers
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pready <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pready <= w_pready_nxt;
    end
  end

  // Next state and wait counter: setup loads, access counts down, deselect aborts
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_sel && !i_penable) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = WAIT_WIDTH'(WAIT_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (!i_sel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WAIT_WIDTH'(1);
        end else if (i_penable) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Ready is registered from the next state so it tracks ACCESS with a zero counter
  always_comb begin
    w_pready_nxt = (w_state_nxt == ST_ACCESS) && (w_cnt_nxt == '0);
    o_access_c   = r_pready && i_sel && i_penable;
  end

  assign o_pready = r_pready;

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer exposing CTRL, STATUS, IRQ, XFER_CNT and four scratch registers.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int unsigned SEL_IDX     = 0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [NUM_SLAVE-1:0]  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  input  logic [DATA_WIDTH-1:0] hw_status,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic                  irq
);

  logic                  w_sel;
  logic                  w_access;
  logic                  w_mapped;
  logic [IDX_WIDTH-1:0]  w_idx_raw;
  reg_idx_e              w_idx;
  logic                  w_wr;
  logic                  w_irq_set;
  logic                  w_irq_clr;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_psel;

  logic [DATA_WIDTH-1:0] r_ctrl;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_xfer_cnt;
  logic [DATA_WIDTH-1:0] r_scratch [NUM_SCRATCH];
  logic                  r_hw0_q;

  assign w_sel         = PSEL[SEL_IDX];
  assign w_unused_psel = ^PSEL;
  assign w_mapped      = addr_mapped(PADDR);
  assign w_idx_raw     = PADDR[4:2];
  assign w_idx         = reg_idx_e'(w_idx_raw);
  assign w_wr          = w_access && PWRITE && w_mapped;
  assign w_irq_set     = hw_status[0] && !r_hw0_q;
  assign w_irq_clr     = w_wr && (w_idx == REG_IRQ) && PWDATA[0];

  apb_completer_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .i_sel      (w_sel),
    .i_penable  (PENABLE),
    .o_pready   (PREADY),
    .o_access_c (w_access)
  );

  // Writable register storage
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_ctrl <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
    end else if (w_wr) begin
      case (w_idx)
        REG_CTRL: r_ctrl <= PWDATA;
        REG_SCRATCH0, REG_SCRATCH1, REG_SCRATCH2, REG_SCRATCH3:
          r_scratch[w_idx_raw[1:0]] <= PWDATA;
        default: ;
      endcase
    end
  end

  // Interrupt flag: rising edge of hw_status[0] sets, W1C clears, set has priority
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_hw0_q <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_hw0_q <= hw_status[0];
      if (w_irq_set)      r_irq <= 1'b1;
      else if (w_irq_clr) r_irq <= 1'b0;
    end
  end

  // Completed-transfer counter, wraps naturally
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET)       r_xfer_cnt <= '0;
    else if (w_access) r_xfer_cnt <= r_xfer_cnt + DATA_WIDTH'(1);
  end

  // Read mux over the word-indexed map
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL:     w_rdata = r_ctrl;
      REG_STATUS:   w_rdata = hw_status;
      REG_IRQ:      w_rdata = DATA_WIDTH'(r_irq);
      REG_XFER_CNT: w_rdata = r_xfer_cnt;
      REG_SCRATCH0, REG_SCRATCH1, REG_SCRATCH2, REG_SCRATCH3:
        w_rdata = r_scratch[w_idx_raw[1:0]];
    endcase
  end

  assign PRDATA   = (PREADY && !PWRITE && w_mapped) ? w_rdata : '0;
  assign ctrl_out = r_ctrl;
  assign irq      = r_irq && r_ctrl[0];

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: one instance with 2 wait states on PSEL[0], one with none on PSEL[1].
module tb_apb_reg_completer;
  import apb_pkg::*;

  logic                  PCLK;
  logic                  PRESET;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [NUM_SLAVE-1:0]  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] hw_status;

  logic                  pready_a, pready_b;
  logic [DATA_WIDTH-1:0] prdata_a, prdata_b;
  logic [DATA_WIDTH-1:0] ctrl_a, ctrl_b;
  logic                  irq_a, irq_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q [$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  apb_reg_completer #(.SEL_IDX(0), .WAIT_CYCLES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready_a), .PRDATA(prdata_a),
    .hw_status(hw_status), .ctrl_out(ctrl_a), .irq(irq_a)
  );

  apb_reg_completer #(.SEL_IDX(1), .WAIT_CYCLES(0)) dut_z (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready_b), .PRDATA(prdata_b),
    .hw_status(hw_status), .ctrl_out(ctrl_b), .irq(irq_b)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    PSEL    = '0;
    PENABLE = 1'b0;
  endtask

  // One APB transfer; the completing edge is left to the caller so transfers can run back to back
  task automatic xfer(input int s, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic raise_hw0, input string name);
    int          exp_acc;
    int          cyc;
    logic        rdy;
    logic [31:0] prd;
    logic [31:0] exp_q;
    exp_acc = (s == 0) ? 3 : 1;
    @(posedge PCLK); #1;
    PSEL    = 4'(1 << s);
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    sb_q.push_back(wr ? 32'h0 : exp_rd);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc     = 0;
    rdy     = 1'b0;
    forever begin
      @(negedge PCLK);
      cyc++;
      rdy = (s == 0) ? pready_a : pready_b;
      if (rdy || cyc >= 20) break;
    end
    if (!rdy) chk({name, "_timeout"}, 32'h0, 32'h1);
    chk({name, "_access_cycles"}, 32'(cyc), 32'(exp_acc));
    prd   = (s == 0) ? prdata_a : prdata_b;
    exp_q = sb_q.pop_front();
    chk({name, "_prdata"}, prd, exp_q);
    if (s != 0) chk({name, "_other_sel_pready"}, 32'(pready_a), 32'h0);
    if (raise_hw0) hw_status[0] = 1'b1;
  endtask

  initial begin
    PRESET    = 1'b0;
    PADDR     = '0;
    PSEL      = '0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    PWDATA    = '0;
    hw_status = 32'hA5A5_0000;

    vecs[0]  = '{1'b1, 32'h10,  32'h1234_5678, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,         32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h00,  32'h0000_00F0, 32'h0};
    vecs[3]  = '{1'b0, 32'h00,  32'h0,         32'h0000_00F0};
    vecs[4]  = '{1'b0, 32'h04,  32'h0,         32'hA5A5_0000};
    vecs[5]  = '{1'b0, 32'h0C,  32'h0,         32'd5};
    vecs[6]  = '{1'b1, 32'h1C,  32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b0, 32'h1C,  32'h0,         32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'h20,  32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 32'h20,  32'h0,         32'h0};
    vecs[10] = '{1'b1, 32'h12,  32'h0000_5555, 32'h0};
    vecs[11] = '{1'b0, 32'h10,  32'h0,         32'h1234_5678};
    vecs[12] = '{1'b0, 32'h08,  32'h0,         32'h0};
    vecs[13] = '{1'b0, 32'h0C,  32'h0,         32'd13};
    vecs[14] = '{1'b0, 32'h00,  32'h0,         32'h0000_00F0};
    vecs[15] = '{1'b1, 32'h0C,  32'h0,         32'h0};
    vecs[16] = '{1'b0, 32'h0C,  32'h0,         32'd16};
    vecs[17] = '{1'b1, 32'h100, 32'h0000_0077, 32'h0};
    vecs[18] = '{1'b0, 32'h00,  32'h0,         32'h0000_00F0};

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready_a", 32'(pready_a), 32'h0);
    chk("rst_prdata_a", prdata_a, 32'h0);
    chk("rst_ctrl_a",   ctrl_a, 32'h0);
    chk("rst_irq_a",    32'(irq_a), 32'h0);
    chk("rst_pready_b", 32'(pready_b), 32'h0);
    chk("rst_ctrl_b",   ctrl_b, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;

    // Table-driven transfers against the 2-wait-state completer, back to back
    for (int i = 0; i < NVEC; i++)
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    idle();
    @(negedge PCLK);
    chk("table_ctrl_out", ctrl_a, 32'h0000_00F0);

    // Zero wait states, back-to-back writes on PSEL[1]
    xfer(1, 1'b1, 32'h00, 32'h1, 32'h0, 1'b0, "zw_wr1");
    xfer(1, 1'b1, 32'h00, 32'h2, 32'h0, 1'b0, "zw_wr2");
    xfer(1, 1'b0, 32'h0C, 32'h0, 32'd2, 1'b0, "zw_cnt");
    idle();
    @(negedge PCLK);
    chk("zw_ctrl_out", ctrl_b, 32'h2);
    chk("zw_ctrl_a_untouched", ctrl_a, 32'h0000_00F0);

    // Interrupt set, set-beats-clear, then plain W1C
    xfer(0, 1'b1, 32'h00, 32'h1, 32'h0, 1'b0, "irq_ctrl");
    idle();
    @(negedge PCLK);
    chk("irq_idle", 32'(irq_a), 32'h0);
    @(posedge PCLK); #1;
    hw_status[0] = 1'b1;
    @(negedge PCLK);
    chk("irq_before_edge", 32'(irq_a), 32'h0);
    @(negedge PCLK);
    chk("irq_after_edge", 32'(irq_a), 32'h1);
    @(posedge PCLK); #1;
    hw_status[0] = 1'b0;
    repeat (2) @(posedge PCLK);
    xfer(0, 1'b1, 32'h08, 32'h1, 32'h0, 1'b1, "irq_w1c_race");
    idle();
    @(negedge PCLK);
    chk("irq_set_wins", 32'(irq_a), 32'h1);
    xfer(0, 1'b0, 32'h08, 32'h0, 32'h1, 1'b0, "irq_rd1");
    xfer(0, 1'b1, 32'h08, 32'h1, 32'h0, 1'b0, "irq_w1c");
    idle();
    @(negedge PCLK);
    chk("irq_cleared", 32'(irq_a), 32'h0);
    xfer(0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, "irq_rd0");
    idle();

    // Abort: PSEL dropped in the second access cycle of a write
    @(posedge PCLK); #1;
    PSEL = 4'b0001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h0000_CAFE;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_acc1_pready", 32'(pready_a), 32'h0);
    @(posedge PCLK); #1;
    PSEL = '0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_acc2_pready", 32'(pready_a), 32'h0);
    @(negedge PCLK);
    chk("abort_after_pready", 32'(pready_a), 32'h0);
    xfer(0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, "abort_scratch1");
    xfer(0, 1'b0, 32'h0C, 32'h0, 32'd25, 1'b0, "abort_cnt");
    idle();

    // Counter wrap from all ones
    @(negedge PCLK);
    force dut.r_xfer_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_xfer_cnt;
    xfer(0, 1'b0, 32'h0C, 32'h0, 32'hFFFF_FFFF, 1'b0, "wrap_pre");
    xfer(0, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, "wrap_post");
    idle();

    // Reset asserted in the middle of a write
    xfer(0, 1'b1, 32'h18, 32'h0000_2222, 32'h0, 1'b0, "rstmid_pre");
    @(posedge PCLK); #1;
    PSEL = 4'b0001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h18; PWDATA = 32'h0000_3333;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    #1;
    chk("rstmid_pready", 32'(pready_a), 32'h0);
    chk("rstmid_prdata", prdata_a, 32'h0);
    chk("rstmid_ctrl_a", ctrl_a, 32'h0);
    chk("rstmid_ctrl_b", ctrl_b, 32'h0);
    chk("rstmid_irq",    32'(irq_a), 32'h0);
    PSEL = '0; PENABLE = 1'b0;
    hw_status[0] = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    xfer(0, 1'b0, 32'h18, 32'h0, 32'h0, 1'b0, "rstmid_scratch2");
    xfer(0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "rstmid_ctrl");
    xfer(0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, "rstmid_irqreg");
    xfer(0, 1'b0, 32'h0C, 32'h0, 32'd3, 1'b0, "rstmid_cnt");
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
